// File: rtl/data_ram_rd_arb_if.sv
// Request, RAM port-B and response signals of the data RAM read arbiter.
// The arbiter uses the slave modport. Requesters, the RAM and the response
// consumer sit on the master side.
interface data_ram_rd_arb_if #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 128
);
  logic              req0_valid;
  logic [AWIDTH-1:0] req0_addr;
  logic              req0_ready;
  logic              req1_valid;
  logic [AWIDTH-1:0] req1_addr;
  logic              req1_ready;
  logic              ram_en_b;
  logic              ram_we_b;
  logic [AWIDTH-1:0] ram_addr_b;
  logic              ram_oreg_ce_b;
  logic [DWIDTH-1:0] ram_rd_data_b;
  logic              rsp_valid;
  logic              rsp_id;
  logic [DWIDTH-1:0] rsp_data;
  logic              rsp_ready;
  logic              busy;

  modport slave (
    input  req0_valid, req0_addr, req1_valid, req1_addr, ram_rd_data_b, rsp_ready,
    output req0_ready, req1_ready, ram_en_b, ram_we_b, ram_addr_b, ram_oreg_ce_b,
           rsp_valid, rsp_id, rsp_data, busy
  );

  modport master (
    output req0_valid, req0_addr, req1_valid, req1_addr, ram_rd_data_b, rsp_ready,
    input  req0_ready, req1_ready, ram_en_b, ram_we_b, ram_addr_b, ram_oreg_ce_b,
           rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/data_ram_rd_arb.sv
// Read-port scheduler for the dual-port data RAM.
// Two requesters share RAM port B through round-robin arbitration. A
// RD_LAT-deep pipeline tracks each read's requester id until the RAM data
// arrives. The data is then captured into a response FIFO. Credits
// (FIFO entries plus reads in flight) keep the FIFO from overflowing.
// RD_LAT must be 1 or 2. FIFO_DEPTH must be a power of two of at least RD_LAT+1.
module data_ram_rd_arb #(
  parameter int AWIDTH     = 12,
  parameter int DWIDTH     = 128,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic              clk,
  input logic              resetn,
  data_ram_rd_arb_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // Latency pipeline: valid bit and requester id per stage
  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] pid_q;

  // Round-robin pointer and output-register enable flag
  logic last_grant_q;
  logic oreg_ce_q;

  // Response FIFO storage and bookkeeping
  logic [DWIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic              fifo_id_q   [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  after_pop;

  // Registered head of the FIFO, driven straight onto rsp_id/rsp_data
  logic [DWIDTH-1:0] head_data_q, head_data_d;
  logic              head_id_q, head_id_d;

  logic [CNT_W-1:0]  inflight;
  logic              can_issue;
  logic              grant;
  logic              grant_id;
  logic              push;
  logic              push_id;
  logic              pop;

  // Count the pipeline stages that carry a read
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CNT_W'(vld_q[i]);
    end
  end

  // A same-cycle pop is not credited back, so issue stays conservative
  assign can_issue = ({1'b0, count_q} + {1'b0, inflight}) < {1'b0, DEPTH_C};

  // Round-robin grant. It is held off while reset is asserted so the RAM
  // enable and the readies drop as soon as reset goes low.
  always_comb begin
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = ~last_grant_q;
    end else begin
      grant_id = bus.req1_valid;
    end
    grant = resetn && can_issue && (bus.req0_valid || bus.req1_valid);
  end

  assign bus.req0_ready    = grant && !grant_id;
  assign bus.req1_ready    = grant && grant_id;
  assign bus.ram_en_b      = grant;
  assign bus.ram_we_b      = 1'b0;
  assign bus.ram_addr_b    = grant ? (grant_id ? bus.req1_addr : bus.req0_addr) : '0;
  assign bus.ram_oreg_ce_b = oreg_ce_q;

  // The last pipeline stage lines up with the RAM data
  assign push    = vld_q[RD_LAT-1];
  assign push_id = pid_q[RD_LAT-1];
  assign pop     = (count_q != '0) && bus.rsp_ready;

  // Next FIFO pointers, count and head. The head register keeps its last
  // value once the FIFO drains.
  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    after_pop   = count_q - CNT_W'(pop);
    count_d     = after_pop + CNT_W'(push);
    head_id_d   = head_id_q;
    head_data_d = head_data_q;
    if (after_pop != '0) begin
      head_id_d   = fifo_id_q[rd_ptr_d];
      head_data_d = fifo_data_q[rd_ptr_d];
    end else if (push) begin
      head_id_d   = push_id;
      head_data_d = bus.ram_rd_data_b;
    end
  end

  assign bus.rsp_valid = (count_q != '0);
  assign bus.rsp_id    = head_id_q;
  assign bus.rsp_data  = head_data_q;
  assign bus.busy      = (inflight != '0) || (count_q != '0);

  // Shift grants through the read-latency pipeline
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q <= '0;
      pid_q <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        vld_q[i] <= vld_q[i-1];
        pid_q[i] <= pid_q[i-1];
      end
      vld_q[0] <= grant;
      pid_q[0] <= grant_id;
    end
  end

  // Arbitration state, control registers and the FIFO head
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant_q <= 1'b1;
      oreg_ce_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_id_q    <= 1'b0;
      head_data_q  <= '0;
    end else begin
      if (grant) begin
        last_grant_q <= grant_id;
      end
      oreg_ce_q   <= 1'b1;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      head_id_q   <= head_id_d;
      head_data_q <= head_data_d;
    end
  end

  // FIFO storage. It needs no reset because the pointers decide what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= bus.ram_rd_data_b;
      fifo_id_q[wr_ptr_q]   <= push_id;
    end
  end

  // The credit scheme must make overflow impossible
  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !(push && (count_q == DEPTH_C)));

  a_credit_bound: assert property (@(posedge clk) disable iff (!resetn)
    ({1'b0, count_q} + {1'b0, inflight}) <= {1'b0, DEPTH_C});

endmodule

// File: tb/tb_data_ram_rd_arb.sv
// Self-checking bench for data_ram_rd_arb.
// One instance uses RD_LAT=2 and another uses RD_LAT=1. They are exercised
// one at a time. A queue-based reference model predicts every output from
// the arbitration and credit rules.
module tb_data_ram_rd_arb;
  localparam int AW    = 12;
  localparam int DW    = 128;
  localparam int DEPTH = 4;

  typedef struct {
    logic          r0, r1, en, we, oce, rv, rid, bsy;
    logic [AW-1:0] addr;
    logic [DW-1:0] rdata;
  } obs_t;

  typedef struct {
    bit            id;
    logic [DW-1:0] data;
    int            due;
  } fly_t;

  typedef struct {
    bit            id;
    logic [DW-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  data_ram_rd_arb_if #(.AWIDTH(AW), .DWIDTH(DW)) busA ();
  data_ram_rd_arb_if #(.AWIDTH(AW), .DWIDTH(DW)) busB ();

  data_ram_rd_arb #(.AWIDTH(AW), .DWIDTH(DW), .RD_LAT(2), .FIFO_DEPTH(DEPTH)) dutA (
    .clk(clk), .resetn(resetn), .bus(busA.slave)
  );

  data_ram_rd_arb #(.AWIDTH(AW), .DWIDTH(DW), .RD_LAT(1), .FIFO_DEPTH(DEPTH)) dutB (
    .clk(clk), .resetn(resetn), .bus(busB.slave)
  );

  // Stimulus variables, routed to whichever instance is selected
  bit            sel;
  bit            v0, v1, rdy;
  logic [AW-1:0] a0, a1;

  assign busA.req0_valid = v0 && (sel == 1'b0);
  assign busA.req1_valid = v1 && (sel == 1'b0);
  assign busA.req0_addr  = a0;
  assign busA.req1_addr  = a1;
  assign busA.rsp_ready  = rdy;
  assign busB.req0_valid = v0 && (sel == 1'b1);
  assign busB.req1_valid = v1 && (sel == 1'b1);
  assign busB.req0_addr  = a0;
  assign busB.req1_addr  = a1;
  assign busB.rsp_ready  = rdy;

  // RAM contents and the port-B read pipeline of each instance
  logic [DW-1:0] ram [4096];
  logic [DW-1:0] pipeA0 = '0;
  logic [DW-1:0] pipeA1 = '0;
  logic [DW-1:0] pipeB0 = '0;

  always @(posedge clk) begin
    if (busA.ram_en_b) pipeA0 <= ram[busA.ram_addr_b];
    pipeA1 <= pipeA0;
    if (busB.ram_en_b) pipeB0 <= ram[busB.ram_addr_b];
  end

  assign busA.ram_rd_data_b = pipeA1;
  assign busB.ram_rd_data_b = pipeB0;

  // Reference model state
  fly_t          flyQ[$];
  ent_t          fifoQ[$];
  bit            lastGrant;
  bit            headId;
  logic [DW-1:0] headData;
  bit            oceExp;
  int            cyc;
  int            lat;
  bit            lastG, lastGid, lastObsR1;
  int            obsGrants;
  int            checks, errors;

  function automatic obs_t getObs();
    obs_t o;
    if (sel == 1'b0) begin
      o.r0 = busA.req0_ready;    o.r1 = busA.req1_ready;
      o.en = busA.ram_en_b;      o.we = busA.ram_we_b;
      o.oce = busA.ram_oreg_ce_b; o.rv = busA.rsp_valid;
      o.rid = busA.rsp_id;       o.bsy = busA.busy;
      o.addr = busA.ram_addr_b;  o.rdata = busA.rsp_data;
    end else begin
      o.r0 = busB.req0_ready;    o.r1 = busB.req1_ready;
      o.en = busB.ram_en_b;      o.we = busB.ram_we_b;
      o.oce = busB.ram_oreg_ce_b; o.rv = busB.rsp_valid;
      o.rid = busB.rsp_id;       o.bsy = busB.busy;
      o.addr = busB.ram_addr_b;  o.rdata = busB.rsp_data;
    end
    return o;
  endfunction

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Drive one cycle (entered just after a falling edge), check every
  // output against the model, then advance the model to the next cycle.
  task automatic applyStimulus(input bit nv0, input logic [AW-1:0] na0,
                               input bit nv1, input logic [AW-1:0] na1, input bit nrdy);
    obs_t          o;
    bit            canIssue, g, gid, hv;
    logic [AW-1:0] gaddr;
    v0 = nv0; a0 = na0; v1 = nv1; a1 = na1; rdy = nrdy;
    #1;
    o        = getObs();
    canIssue = (fifoQ.size() + flyQ.size()) < DEPTH;
    g        = canIssue && (nv0 || nv1);
    gid      = (nv0 && nv1) ? ~lastGrant : nv1;
    gaddr    = g ? (gid ? na1 : na0) : AW'(0);
    hv       = fifoQ.size() != 0;
    if (hv) begin
      headId   = fifoQ[0].id;
      headData = fifoQ[0].data;
    end
    checkOutput("req0_ready", DW'(o.r0), DW'(g && !gid));
    checkOutput("req1_ready", DW'(o.r1), DW'(g && gid));
    checkOutput("ram_en_b", DW'(o.en), DW'(g));
    checkOutput("ram_addr_b", DW'(o.addr), DW'(gaddr));
    checkOutput("ram_we_b", DW'(o.we), DW'(1'b0));
    checkOutput("ram_oreg_ce_b", DW'(o.oce), DW'(oceExp));
    checkOutput("rsp_valid", DW'(o.rv), DW'(hv));
    checkOutput("rsp_id", DW'(o.rid), DW'(headId));
    checkOutput("rsp_data", o.rdata, headData);
    checkOutput("busy", DW'(o.bsy), DW'(hv || (flyQ.size() != 0)));
    lastG     = g;
    lastGid   = gid;
    lastObsR1 = o.r1;
    if (hv && nrdy) void'(fifoQ.pop_front());
    while (flyQ.size() != 0 && flyQ[0].due == cyc) begin
      fifoQ.push_back('{id: flyQ[0].id, data: flyQ[0].data});
      void'(flyQ.pop_front());
    end
    if (g) begin
      flyQ.push_back('{id: gid, data: ram[gaddr], due: cyc + lat});
      lastGrant = gid;
    end
    @(posedge clk);
    cyc++;
    oceExp = 1'b1;
    @(negedge clk);
  endtask

  // Assert reset between clock edges and check that the outputs drop at once, even with requests pending
  task automatic doReset();
    obs_t o;
    v0 = 1'b1; v1 = 1'b1; rdy = 1'b1;
    resetn = 1'b0;
    #1;
    o = getObs();
    checkOutput("rst_req0_ready", DW'(o.r0), DW'(1'b0));
    checkOutput("rst_req1_ready", DW'(o.r1), DW'(1'b0));
    checkOutput("rst_ram_en_b", DW'(o.en), DW'(1'b0));
    checkOutput("rst_ram_addr_b", DW'(o.addr), DW'(0));
    checkOutput("rst_oreg_ce", DW'(o.oce), DW'(1'b0));
    checkOutput("rst_rsp_valid", DW'(o.rv), DW'(1'b0));
    checkOutput("rst_rsp_id", DW'(o.rid), DW'(1'b0));
    checkOutput("rst_rsp_data", o.rdata, DW'(0));
    checkOutput("rst_busy", DW'(o.bsy), DW'(1'b0));
    flyQ.delete();
    fifoQ.delete();
    lastGrant = 1'b1;
    headId    = 1'b0;
    headData  = '0;
    oceExp    = 1'b0;
    lastG     = 1'b0;
    v0 = 1'b0; v1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Random traffic in which each requester holds valid and addr until it is granted
  task automatic randomPhase(input int n, input int pv, input int pr);
    bit            nv0, nv1;
    logic [AW-1:0] na0, na1;
    nv0 = v0; nv1 = v1; na0 = a0; na1 = a1;
    for (int i = 0; i < n; i++) begin
      if (!nv0 || (lastG && !lastGid)) begin
        nv0 = ($urandom_range(99) < pv);
        na0 = AW'($urandom);
      end
      if (!nv1 || (lastG && lastGid)) begin
        nv1 = ($urandom_range(99) < pv);
        na1 = AW'($urandom);
      end
      applyStimulus(nv0, na0, nv1, na1, $urandom_range(99) < pr);
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; lat = 2; sel = 1'b0;
    v0 = 1'b0; v1 = 1'b0; rdy = 1'b0; a0 = '0; a1 = '0;
    for (int i = 0; i < 4096; i++) ram[i] = {$urandom, $urandom, $urandom, $urandom};
    ram[12'h010] = {16{8'hA5}};
    resetn = 1'b1;
    #2;

    $display("[TB] RD_LAT=2: reset and single read");
    doReset();
    applyStimulus(1'b1, 12'h010, 1'b0, 12'h000, 1'b1);
    repeat (5) applyStimulus(1'b0, 12'h000, 1'b0, 12'h000, 1'b1);

    $display("[TB] RD_LAT=2: backpressure");
    obsGrants = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 12'h000, 1'b1, AW'(12'h100 + obsGrants), 1'b0);
      obsGrants += int'(lastObsR1);
    end
    checkOutput("bp_grants", DW'(obsGrants), DW'(DEPTH));
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 12'h000, 1'b1, AW'(12'h200 + i), 1'b1);
    repeat (6) applyStimulus(1'b0, 12'h000, 1'b0, 12'h000, 1'b1);

    $display("[TB] RD_LAT=2: random traffic");
    randomPhase(300, 60, 70);
    repeat (8) applyStimulus(1'b0, 12'h000, 1'b0, 12'h000, 1'b1);

    $display("[TB] RD_LAT=2: reset with reads in flight and entries queued");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, AW'(12'h040 + i), 1'b0, 12'h000, 1'b0);
    doReset();
    repeat (4) applyStimulus(1'b1, 12'h001, 1'b1, 12'h002, 1'b1);
    repeat (6) applyStimulus(1'b0, 12'h000, 1'b0, 12'h000, 1'b1);

    $display("[TB] RD_LAT=1: address edge, push/pop at count 3, random traffic");
    sel = 1'b1;
    lat = 1;
    doReset();
    applyStimulus(1'b1, 12'hFFF, 1'b0, 12'h000, 1'b1);
    repeat (3) applyStimulus(1'b0, 12'h000, 1'b0, 12'h000, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, AW'(12'h300 + i), 1'b0, 12'h000, 1'b0);
    repeat (2) applyStimulus(1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
    applyStimulus(1'b1, 12'h3A0, 1'b0, 12'h000, 1'b0);
    applyStimulus(1'b0, 12'h000, 1'b0, 12'h000, 1'b1);
    repeat (6) applyStimulus(1'b0, 12'h000, 1'b0, 12'h000, 1'b1);
    randomPhase(200, 60, 60);
    repeat (8) applyStimulus(1'b0, 12'h000, 1'b0, 12'h000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
